// File: rtl/io_ctrl.sv
// io_ctrl: board I/O port controller (button debounce, operand latches, ready flags, LED register)
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   switch_in[7:0]      raw operand switches
//   test_in[2:0]        raw test-case selector switches
//   btn_a, btn_b        raw, bouncy enter buttons for operands A and B
//   io_read, io_write   CPU load/store targets I/O space this cycle
//   addr[31:0]          access address (ALU result)
//   wdata[31:0]         store data
//   io_rdata[31:0]      combinational read data for the memory/IO result mux
//   led_out[23:0]       LED drive
//   ready_a, ready_b    new-operand flags, cleared by reading the operand
//
// The IO_*_ADDR parameters mirror the address macros of includes/defines.v.

module io_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t state;
    logic [CW-1:0] cnt;

    // Decoded from the transition so the operand latches on the same edge the press is accepted.
    assign press = (state == PRESS_WAIT) && btn && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (btn) begin
                    state <= PRESS_WAIT;
                    cnt   <= '0;
                end
                PRESS_WAIT: if (!btn) state <= IDLE;
                    else if (cnt == LAST) state <= HELD;
                    else cnt <= cnt + CW'(1);
                HELD: if (!btn) begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end
                RELEASE_WAIT: if (btn) state <= HELD;
                    else if (cnt == LAST) state <= IDLE;
                    else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module io_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter logic [31:0] IO_A_ADDR       = 32'hFFFF_FC00,
    parameter logic [31:0] IO_B_ADDR       = 32'hFFFF_FC04,
    parameter logic [31:0] IO_TEST_ADDR    = 32'hFFFF_FC08,
    parameter logic [31:0] IO_STATUS_ADDR  = 32'hFFFF_FC0C,
    parameter logic [31:0] IO_LED_ADDR     = 32'hFFFF_FC10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  switch_in,
    input  logic [2:0]  test_in,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] io_rdata,
    output logic [23:0] led_out,
    output logic        ready_a,
    output logic        ready_b
);
    logic [12:0] meta, sync;
    logic [7:0]  sw_s, a_reg, b_reg;
    logic [2:0]  test_s;
    logic        btn_a_s, btn_b_s, press_a, press_b, rd_a, rd_b;
    logic [23:0] led_reg;
    logic        unused_wdata;

    assign {btn_b_s, btn_a_s, test_s, sw_s} = sync;
    assign unused_wdata = ^wdata[31:24];

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {btn_b, btn_a, test_in, switch_in};
            sync <= meta;
        end
    end

    io_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clock(clock), .reset(reset), .btn(btn_a_s), .press(press_a)
    );

    io_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clock(clock), .reset(reset), .btn(btn_b_s), .press(press_b)
    );

    assign rd_a = io_read && (addr == IO_A_ADDR);
    assign rd_b = io_read && (addr == IO_B_ADDR);

    // A press landing on the same edge as a read-clear wins: the flag stays set.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            ready_a <= 1'b0;
            ready_b <= 1'b0;
            led_reg <= '0;
        end else begin
            if (press_a) a_reg <= sw_s;
            if (press_b) b_reg <= sw_s;
            ready_a <= press_a | (ready_a & ~rd_a);
            ready_b <= press_b | (ready_b & ~rd_b);
            if (io_write && addr == IO_LED_ADDR) led_reg <= wdata[23:0];
        end
    end

    assign led_out = led_reg;

    always_comb begin
        io_rdata = !io_read                ? 32'b0 :
                   addr == IO_A_ADDR      ? {24'b0, a_reg} :
                   addr == IO_B_ADDR      ? {24'b0, b_reg} :
                   addr == IO_TEST_ADDR   ? {29'b0, test_s} :
                   addr == IO_STATUS_ADDR ? {30'b0, ready_b, ready_a} :
                   addr == IO_LED_ADDR    ? {8'b0, led_reg} : 32'b0;
    end
endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: self-checking bench for io_ctrl with a run-length model of the debounced buttons
module tb_io_ctrl;
    localparam int D = 4;
    localparam logic [31:0] A_ADDR = 32'hFFFF_FC00;
    localparam logic [31:0] B_ADDR = 32'hFFFF_FC04;
    localparam logic [31:0] T_ADDR = 32'hFFFF_FC08;
    localparam logic [31:0] S_ADDR = 32'hFFFF_FC0C;
    localparam logic [31:0] L_ADDR = 32'hFFFF_FC10;

    logic        clock = 0, reset = 1;
    logic [7:0]  switch_in = 0;
    logic [2:0]  test_in = 0;
    logic        btn_a = 0, btn_b = 0, io_read = 0, io_write = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] io_rdata;
    logic [23:0] led_out;
    logic        ready_a, ready_b;
    int          compared = 0, mismatched = 0;

    always #5 clock = ~clock;

    io_ctrl #(
        .DEBOUNCE_CYCLES(D), .IO_A_ADDR(A_ADDR), .IO_B_ADDR(B_ADDR),
        .IO_TEST_ADDR(T_ADDR), .IO_STATUS_ADDR(S_ADDR), .IO_LED_ADDR(L_ADDR)
    ) dut (
        .clock(clock), .reset(reset), .switch_in(switch_in), .test_in(test_in),
        .btn_a(btn_a), .btn_b(btn_b), .io_read(io_read), .io_write(io_write),
        .addr(addr), .wdata(wdata), .io_rdata(io_rdata), .led_out(led_out),
        .ready_a(ready_a), .ready_b(ready_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: inputs reach the debouncer two edges late; a press is accepted once the
    // delayed level has been high for D+1 consecutive edges while armed, and the
    // button re-arms after D+1 consecutive low edges.
    bit          valid = 0;
    logic [7:0]  sw0, sw1, m_a, m_b;
    logic [2:0]  t0, t1;
    logic        ba0, ba1, bb0, bb1, m_ra, m_rb;
    logic [23:0] m_led;
    int          hi[2], lo[2];
    bit          armed[2], ev[2];
    logic        lvl[2];

    always @(posedge clock) begin
        if (reset) begin
            valid = 1;
            sw0 = 0; sw1 = 0; t0 = 0; t1 = 0;
            ba0 = 0; ba1 = 0; bb0 = 0; bb1 = 0;
            m_a = 0; m_b = 0; m_ra = 0; m_rb = 0; m_led = 0;
            for (int i = 0; i < 2; i++) begin
                hi[i] = 0; lo[i] = 0; armed[i] = 1;
            end
        end else begin
            lvl[0] = ba1;
            lvl[1] = bb1;
            for (int i = 0; i < 2; i++) begin
                ev[i] = 0;
                if (lvl[i]) begin hi[i]++; lo[i] = 0; end
                else begin lo[i]++; hi[i] = 0; end
                if (armed[i] && hi[i] == D + 1) begin ev[i] = 1; armed[i] = 0; end
                else if (!armed[i] && lo[i] == D + 1) armed[i] = 1;
            end
            if (ev[0]) begin m_a = sw1; m_ra = 1; end
            else if (io_read && addr == A_ADDR) m_ra = 0;
            if (ev[1]) begin m_b = sw1; m_rb = 1; end
            else if (io_read && addr == B_ADDR) m_rb = 0;
            if (io_write && addr == L_ADDR) m_led = wdata[23:0];
            sw1 = sw0; sw0 = switch_in;
            t1 = t0;   t0 = test_in;
            ba1 = ba0; ba0 = btn_a;
            bb1 = bb0; bb0 = btn_b;
        end
    end

    function automatic logic [31:0] exp_rdata();
        if (!io_read) return 32'b0;
        case (addr)
            A_ADDR:  return {24'b0, m_a};
            B_ADDR:  return {24'b0, m_b};
            T_ADDR:  return {29'b0, t1};
            S_ADDR:  return {30'b0, m_rb, m_ra};
            L_ADDR:  return {8'b0, m_led};
            default: return 32'b0;
        endcase
    endfunction

    always @(negedge clock) begin
        if (valid) begin
            check("cyc ready_a", 32'(ready_a), 32'(m_ra));
            check("cyc ready_b", 32'(ready_b), 32'(m_rb));
            check("cyc led_out", 32'(led_out), 32'(m_led));
            check("cyc io_rdata", io_rdata, exp_rdata());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        cyc(2);
        reset = 0;
        @(negedge clock);
        check("rst led_out", 32'(led_out), 32'h0);
        check("rst ready_a", 32'(ready_a), 32'h0);
        cyc(1); io_read = 1; addr = A_ADDR;
        @(negedge clock); check("rst read A", io_rdata, 32'h0);
        cyc(1); io_read = 0; switch_in = 8'h5A; test_in = 3'd5;
        cyc(3);
        // operand A: flag rises on the 7th edge after btn_a goes high
        btn_a = 1;
        cyc(6);
        @(negedge clock); check("A edge6", 32'(ready_a), 32'h0);
        cyc(1);
        @(negedge clock); check("A edge7", 32'(ready_a), 32'h1);
        cyc(1); io_read = 1; addr = A_ADDR;
        @(negedge clock); check("read A", io_rdata, 32'h5A);
        cyc(1); io_read = 0;
        @(negedge clock); check("A cleared", 32'(ready_a), 32'h0);
        cyc(20);
        @(negedge clock); check("A no relatch", 32'(ready_a), 32'h0);
        btn_a = 0;
        cyc(10);
        // operand B: bounces rejected, then a clean press
        switch_in = 8'hC3;
        cyc(3);
        btn_b = 1; cyc(3);
        btn_b = 0; cyc(1);
        btn_b = 1; cyc(2);
        btn_b = 0; cyc(10);
        @(negedge clock); check("bounce ready_b", 32'(ready_b), 32'h0);
        cyc(1); io_read = 1; addr = B_ADDR;
        @(negedge clock); check("bounce b_reg", io_rdata, 32'h0);
        cyc(1); io_read = 0;
        btn_b = 1;
        cyc(10);
        btn_b = 0; io_read = 1; addr = S_ADDR;
        @(negedge clock);
        check("B latched", 32'(ready_b), 32'h1);
        check("status", io_rdata, 32'h2);
        cyc(1); addr = B_ADDR;
        @(negedge clock);
        check("status keeps B", 32'(ready_b), 32'h1);
        check("read B", io_rdata, 32'hC3);
        cyc(1); io_read = 0;
        @(negedge clock); check("B cleared", 32'(ready_b), 32'h0);
        cyc(10);
        // collision: read of A sampled on the very edge A latches
        switch_in = 8'h33;
        cyc(3);
        btn_a = 1;
        cyc(6); io_read = 1; addr = A_ADDR;
        @(negedge clock); check("old A", io_rdata, 32'h5A);
        cyc(1); io_read = 0;
        @(negedge clock); check("collision flag", 32'(ready_a), 32'h1);
        cyc(1); io_read = 1; addr = A_ADDR;
        @(negedge clock); check("collision data", io_rdata, 32'h33);
        cyc(1); io_read = 0; btn_a = 0;
        @(negedge clock); check("A cleared 2", 32'(ready_a), 32'h0);
        cyc(10);
        // LED register
        io_write = 1; addr = L_ADDR; wdata = 32'hFFABCDEF;
        @(negedge clock); check("led before", 32'(led_out), 32'h0);
        cyc(1); io_write = 0; io_read = 1;
        @(negedge clock);
        check("led write", 32'(led_out), 32'hABCDEF);
        check("led read", io_rdata, 32'h00ABCDEF);
        cyc(1); io_read = 0; io_write = 1; addr = A_ADDR; wdata = 32'h12345678;
        cyc(1); io_write = 0;
        @(negedge clock); check("led other addr", 32'(led_out), 32'hABCDEF);
        cyc(1); io_read = 1; io_write = 1; addr = L_ADDR; wdata = 32'h00112233;
        @(negedge clock); check("rw old", io_rdata, 32'h00ABCDEF);
        cyc(1); io_write = 0;
        @(negedge clock); check("rw new", io_rdata, 32'h00112233);
        cyc(1); addr = T_ADDR;
        @(negedge clock); check("test read", io_rdata, 32'h5);
        cyc(1); addr = 32'h0000_1000;
        @(negedge clock); check("unmapped read", io_rdata, 32'h0);
        cyc(1); io_read = 0;
        // reset in the middle of a press
        switch_in = 8'h77;
        cyc(3);
        btn_a = 1;
        cyc(4);
        reset = 1;
        cyc(1);
        reset = 0;
        @(negedge clock);
        check("reset ready_a", 32'(ready_a), 32'h0);
        check("reset led", 32'(led_out), 32'h0);
        cyc(6);
        @(negedge clock); check("post-reset edge6", 32'(ready_a), 32'h0);
        cyc(1);
        @(negedge clock); check("post-reset edge7", 32'(ready_a), 32'h1);
        cyc(1); io_read = 1; addr = A_ADDR;
        @(negedge clock); check("post-reset A", io_rdata, 32'h77);
        cyc(1); io_read = 0; btn_a = 0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/io_ctrl.md
# io_ctrl

Controller for the CPU's board I/O port: it conditions the raw operand buttons and switches, latches operands A and B, and tracks per-operand "new data" flags that software polls and clears. It also holds the 24-bit LED register written by store instructions. It sits between the board pins and the CPU's memory/IO result mux, decoding `IORead`/`IOWrite` accesses by ALU-computed address against the address macros in `includes/defines.v`.

## Interface
- `DEBOUNCE_CYCLES`, 100000: cycles a synchronized button level must stay stable before it is accepted; legal range 2..2^20.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `switch_in`  in  8  raw operand switches.
- `test_in`  in  3  raw test-case selector switches.
- `btn_a`, `btn_b`  in  1 each  raw enter buttons for operands A and B; active high, bouncy.
- `io_read`  in  1  CPU load targets I/O space this cycle.
- `io_write`  in  1  CPU store targets I/O space this cycle.
- `addr`  in  32  ALU result, i.e. the access address.
- `wdata`  in  32  store data.
- `io_rdata`  out  32  read data for the memory/IO result mux.
- `led_out`  out  24  LED drive.
- `ready_a`, `ready_b`  out  1 each  new-operand flags; also wired to status LEDs.

## Operation
- Synchronizers: 2-flop chains on `btn_a`, `btn_b`, `switch_in`, `test_in`; all logic uses synchronized versions.
- Per button, an independent 4-state debounce FSM with a counter `cnt`:
  - IDLE: sync high -> PRESS_WAIT, `cnt`=0.
  - PRESS_WAIT: sync low -> IDLE (bounce rejected). If sync high and `cnt`==DEBOUNCE_CYCLES-1 -> HELD, emit latch event; otherwise `cnt`++.
  - HELD: sync low -> RELEASE_WAIT, `cnt`=0.
  - RELEASE_WAIT: sync high -> HELD with no new latch event. If sync low and `cnt`==DEBOUNCE_CYCLES-1 -> IDLE; otherwise `cnt`++.
- One latch event per accepted press, regardless of how long the button is held.
- Latch event A: `a_reg` <= synchronized switches, `ready_a` <= 1. Same for B.
- Read decode applies only when `io_read`=1; otherwise `io_rdata`=0:
  - `IO_A_ADDR` -> {24'b0,`a_reg`}
  - `IO_B_ADDR` -> {24'b0,`b_reg`}
  - `IO_TEST_ADDR` -> {29'b0,synced test}
  - `IO_STATUS_ADDR` -> {30'b0,`ready_b`,`ready_a`}
  - `IO_LED_ADDR` -> {8'b0,`led_reg`}
  - any other address -> 0.
- Read clear: `io_read` at `IO_A_ADDR` clears `ready_a` on the next edge; same for B. Reading the status register does not clear the flags.
- Set/clear collision: a latch event and a read-clear on the same edge leave the flag at 1 and load `a_reg`/`b_reg` with the new value.
- LED write: `io_write` with `addr`==`IO_LED_ADDR` sets `led_reg` <= `wdata[23:0]`. Writes to any other address are ignored. `led_out`=`led_reg`.
- `io_read` and `io_write` asserted together: both act independently.

## Timing
- Reset, on a synchronous edge: FSMs to IDLE, `cnt`=0, synchronizers=0, `a_reg`=`b_reg`=0, `ready_a`=`ready_b`=0, `led_reg`=0. Resulting outputs: `led_out`=0, `io_rdata`=0 while `io_read`=0.
- Reset mid-debounce aborts the press. A button still held after reset must first re-enter PRESS_WAIT and complete the full count.
- Press latency: with the button held stable, the latch (flag rise) occurs DEBOUNCE_CYCLES+3 rising edges after the first edge that samples `btn` high.
- Release: the next press can be accepted only after DEBOUNCE_CYCLES+1 edges of stable synchronized low.
- `io_rdata` is combinational from registered state, `addr` and `io_read`, with zero-cycle read latency. The flag clear is visible on the cycle after the read.
- LED write takes effect on the edge where `io_write` is sampled; `led_out` updates the following cycle.
- `cnt` never exceeds DEBOUNCE_CYCLES-1 and does not wrap.

## Test plan (DEBOUNCE_CYCLES=4)
- Reset, then idle: `led_out`=0, `ready_a`=0; with `io_read`=1 and `addr`=`IO_A_ADDR`, `io_rdata`=0.
- `switch_in`=8'h5A, `btn_a` held high: `ready_a` rises on edge 7; read at `IO_A_ADDR` returns 32'h5A; `ready_a`=0 the next cycle. Keep holding 20 cycles: no second latch.
- Bounce: `btn_b` high 3 cycles, low 1, high 2, then low: `ready_b` stays 0 and `b_reg` is unchanged. A later clean 10-cycle press latches B.
- Collision: a read of A on exactly the edge a new A latch fires (switches 8'h33): `ready_a` stays 1 and a subsequent read returns 32'h33.
- Store 32'hFFABCDEF to `IO_LED_ADDR` -> `led_out`=24'hABCDEF and a read at `IO_LED_ADDR` returns 32'h00ABCDEF. Store to `IO_A_ADDR` -> `led_out` unchanged.
- Assert `reset` during PRESS_WAIT with `btn_a` held: `ready_a`=0 after reset, and it rises 7 edges after reset deasserts.
